mult_div_unit: RTL and testbench

Iterative multiply/divide unit that executes MULT, MULTU, DIV and DIVU beside the integer ALU in the execute stage, and owns the architectural HI/LO registers. The ALU handles only single-cycle operations. The control path issues a start, stalls while busy is high, and reads hi/lo afterwards for MFHI/MFLO. MTHI/MTLO write HI/LO directly through this block.

---
 rtl/mips_mdu_pkg.sv | 22 ++
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 tb/tb_mult_div_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM states and the iteration-counter width helper.
package mips_mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    // Counter must hold 0..WIDTH-1 with headroom for the terminal compare.
    function automatic int mdu_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Operands are converted to magnitudes on start, iterated radix-2 for WIDTH
// cycles in a shared 2*WIDTH shift register, then signs are applied in FIX.
import mips_mdu_pkg::*;

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = mdu_cnt_width(WIDTH);

    mdu_state_t         r_state;
    mdu_state_t         w_state_next;
    logic               r_is_div;
    logic [WIDTH-1:0]   r_opb;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_busy;
    logic               w_done;
    logic               w_start_ok;
    logic               w_signed_in;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // A start is only honoured when no operation is in flight.
    assign w_start_ok  = start && (r_state == IDLE || r_state == DONE);
    assign w_signed_in = ~op[0];
    assign w_abs1      = (w_signed_in && op1[WIDTH-1]) ? -op1 : op1;
    assign w_abs2      = (w_signed_in && op2[WIDTH-1]) ? -op2 : op2;

    // Multiply step: conditionally add multiplicand to the upper half, shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: shift remainder left, trial-subtract, restore on borrow.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_rem_sh - {1'b0, r_opb};
    assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    // Sign fix-up. With a zero divisor the remainder magnitude is |op1| and
    // takes the dividend sign, so it reproduces op1; only LO needs forcing.
    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quot = r_div0 ? '1 : (r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start) w_state_next = RUN;
            RUN:  if (r_cnt == CW'(WIDTH - 1)) w_state_next = FIX;
            FIX:  w_state_next = DONE;
            DONE: w_state_next = start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            RUN, FIX: w_busy = 1'b1;
            DONE:     w_done = 1'b1;
            default:  ;
        endcase
    end

    // Operand latch and shared iteration datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_div  <= 1'b0;
            r_opb     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
        end else if (w_start_ok) begin
            r_is_div  <= op[1];
            r_opb     <= w_abs2;
            r_acc     <= {{WIDTH{1'b0}}, w_abs1};
            r_cnt     <= '0;
            r_neg_res <= w_signed_in && (op1[WIDTH-1] ^ op2[WIDTH-1]);
            r_neg_rem <= w_signed_in && op1[WIDTH-1];
            r_div0    <= op[1] && (op2 == '0);
        end else if (r_state == RUN) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // HI/LO: loaded at FIX, otherwise only by MTHI/MTLO when idle and not starting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == FIX) begin
            r_hi <= r_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
            r_lo <= r_is_div ? w_quot : w_prod[WIDTH-1:0];
        end else if (!w_busy && !w_start_ok) begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
        end
    end

    assign busy = w_busy;
    assign done = w_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected {hi,lo} pushed on start,
// popped and compared whenever done pulses.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] sb_q[$];

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .op1(op1), .op2(op2),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check_result(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Reference model for random cases.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        case (o)
            2'b00: begin
                sp = 64'($signed(a)) * 64'($signed(b));
                return sp;
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Scoreboard: compare HI/LO against the oldest expectation on each done.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                check_result("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check_result("result_hilo", {hi, lo}, e);
            end
        end
    end

    // Drive one start (at a negedge) and wait for done; returns cycle latency.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, output int lat);
        op = o; op1 = a; op2 = b; start = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check_result("done_timeout", 64'(lat), 64'd34);
    endtask

    initial begin
        int lat;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  ro;
        logic [31:0] hold_hi;

        reset = 1'b1; start = 1'b0; op = 2'b00; op1 = '0; op2 = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        check_result("reset_state", {30'd0, busy, done, hi, lo}, 66'd0);
        reset = 1'b0;
        @(negedge clk);

        // MULTU with latency and busy-window checks.
        op = 2'b01; op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF; start = 1'b1;
        sb_q.push_back({32'hFFFFFFFE, 32'h00000001});
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        check_result("busy_cycle1", {busy, done}, 2'b10);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 5)  check_result("hilo_stable_run", {hi, lo}, 64'd0);
            if (lat == 33) check_result("busy_cycle33", {busy, done}, 2'b10);
        end
        check_result("multu_latency", 64'(lat), 64'd34);
        check_result("done_busy_low", {busy, done}, 2'b01);
        @(negedge clk);
        check_result("done_one_cycle", {busy, done}, 2'b00);

        run_op(2'b00, 32'hFFFFFFFD, 32'd7,        {32'hFFFFFFFF, 32'hFFFFFFEB}, lat);
        run_op(2'b00, 32'h80000000, 32'h80000000, {32'h40000000, 32'h00000000}, lat);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, lat);
        run_op(2'b11, 32'hFFFFFFF9, 32'd2,        {32'h00000001, 32'h7FFFFFFC}, lat);
        run_op(2'b11, 32'd100,      32'd0,        {32'h00000064, 32'hFFFFFFFF}, lat);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, lat);
        check_result("div_latency", 64'(lat), 64'd34);
        run_op(2'b10, 32'hFFFFFF9C, 32'd0,        {32'hFFFFFF9C, 32'hFFFFFFFF}, lat);

        // Start and MTHI while busy are ignored.
        op = 2'b00; op1 = 32'd6; op2 = 32'hFFFFFFFE; start = 1'b1;
        sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF4});
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        op = 2'b01; op1 = 32'd9; op2 = 32'd9; start = 1'b1; mthi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        lat = 6;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_result("busy_start_ignored_lat", 64'(lat), 64'd34);
        @(negedge clk);
        hold_hi = hi;
        mtlo = 1'b1; wdata = 32'hABCD;
        @(negedge clk);
        mtlo = 1'b0;
        check_result("mtlo_write", {hi, lo}, {hold_hi, 32'h0000ABCD});
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A0001;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check_result("mthi_mtlo_both", {hi, lo}, {32'h5A5A0001, 32'h5A5A0001});

        // MTLO coinciding with an accepted start is dropped.
        op = 2'b01; op1 = 32'd2; op2 = 32'd3; start = 1'b1; mtlo = 1'b1; wdata = 32'h77;
        sb_q.push_back({32'd0, 32'd6});
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        check_result("mtlo_dropped_on_start", {hi, lo}, {32'h5A5A0001, 32'h5A5A0001});
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);

        // Reset in the middle of a DIV aborts it.
        op = 2'b10; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check_result("reset_mid_div", {30'd0, busy, done, hi, lo}, 66'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // MULTU after reset, then back-to-back start in the DONE cycle.
        run_op(2'b01, 32'd3, 32'd5, {32'd0, 32'd15}, lat);
        run_op(2'b11, 32'd1000, 32'd7, {32'd6, 32'd142}, lat);
        check_result("back_to_back_latency", 64'(lat), 64'd34);

        // Random cases against the reference model.
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            run_op(ro, ra, rb, model(ro, ra, rb), lat);
        end
        @(negedge clk);
        check_result("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
